gpio_edge_ctrl: RTL and testbench
=================================

Name: gpio_edge_ctrl

Overview:
Parametrised GPIO controller for the RISC-V MCU. Replaces the fixed 32-bit direct gpio_input/gpio_output wiring with a register-mapped block that provides:
- per-pin direction and output registers, including atomic set/clear;
- a synchronised input view;
- per-pin rising/falling edge detection with sticky status and one interrupt line to the core.

It sits on the peripheral register bus next to the UART.

Parameters:
- WIDTH, 32, number of GPIO pins (1..32).
- SYNC_STAGES, 2, input synchroniser depth (2..4).
- ADDR_W, 5, byte-address width of the register window.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  1  register access strobe, single cycle.
- we  in  1  1 = write, 0 = read; qualified by req.
- addr  in  ADDR_W  byte address; bits [1:0] ignored.
- wdata  in  32  write data; bits above WIDTH ignored.
- rdata  out  32  read data; bits above WIDTH read 0.
- rvalid  out  1  read data valid.
- gpio_input  in  WIDTH  asynchronous pad inputs.
- gpio_output  out  WIDTH  output register value.
- gpio_direction  out  WIDTH  1 = output enable per pin.
- irq  out  1  interrupt, level-high.

Behaviour:
- Register map (word offsets):
  - 0x00 DIR, RW.
  - 0x04 OUT, RW.
  - 0x08 IN, RO, synchronised pins.
  - 0x0C RISE_EN, RW.
  - 0x10 FALL_EN, RW.
  - 0x14 STATUS, read / write-1-to-clear.
  - 0x18 OUT_SET, WO: OUT |= wdata.
  - 0x1C OUT_CLR, WO: OUT &= ~wdata.
  - Unmapped or WO reads return 0. Writes to RO or unmapped addresses are ignored.
- Reset values: all registers, sync chain, prev-sample register, rdata, rvalid, irq = 0. Warm-up counter = 0.
- Bus timing:
  - Write takes effect at the clock edge where req&we is high.
  - Read: rdata/rvalid are registered. rvalid is high exactly one cycle after a req&~we cycle; rdata is valid in that cycle. Otherwise rvalid = 0 and rdata holds its last value.
  - Back-to-back reqs are allowed every cycle. No stall.
- Synchroniser: gpio_input passes through a SYNC_STAGES flop chain. IN reflects the last stage.
- Edge detection:
  - prev <= sync each cycle.
  - rise = sync & ~prev; fall = ~sync & prev.
  - STATUS[i] sets on the edge where (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]).
  - Latency: a pin change setup-met before edge k sets STATUS at edge k+SYNC_STAGES.
- Warm-up:
  - Edge detection is masked until a saturating counter reaches SYNC_STAGES+1 cycles after reset deassertion.
  - Pins already high at reset release must not set STATUS.
- STATUS W1C: a bit written 1 clears. If a set event and a clear hit the same bit in the same cycle, set wins and the bit stays 1.
- irq: registered. irq = |STATUS, updated one cycle after STATUS changes. Enable bits do not mask already-set STATUS bits. Clearing RISE_EN/FALL_EN only stops new sets.
- OUT_SET and OUT_CLR writes are single-cycle atomic read-modify-write in the block.
- gpio_output = OUT and gpio_direction = DIR, directly from the registers with no pad muxing. Pins with DIR=1 still sample normally through the synchroniser.
- Async reset mid-transaction: in-flight read is dropped (rvalid=0). All state returns to reset values immediately. Warm-up restarts.

Test Plan:
1. Reset / readback: hold reset_n low 10 cycles then release. Read all 8 offsets → all 0; rvalid exactly 1 cycle after each req; gpio_output=0, gpio_direction=0, irq=0.
2. Output control:
   - Write DIR=0xFFFF_FFFF, then OUT=0x0000_00F0 → gpio_output=0xF0.
   - OUT_SET 0x1 → gpio_output=0xF1.
   - OUT_CLR 0xF0 → gpio_output=0x01; reading OUT returns 0x01.
3. Rising edge IRQ: RISE_EN=0x1, drive gpio_input[0] 0→1 before edge k.
   - STATUS[0]=1 at edge k+2; irq=1 at edge k+3.
   - Write STATUS=0x1 → STATUS=0, irq=0 next cycle.
4. Falling/masking: FALL_EN=0x2, RISE_EN=0.
   - Toggle pin1 0→1 → no status.
   - Toggle pin1 1→0 → STATUS=0x2.
   - Toggle pin0 either way → STATUS[0] stays 0.
5. Simultaneous set/clear: hold STATUS[0]=1 and time a new pin0 rising edge to coincide with a W1C write of 0x1 → STATUS[0] reads 1 afterwards.
6. Warm-up and parametrisation:
   - gpio_input=0xFF during reset with RISE_EN=0xFF → STATUS stays 0 after release.
   - Rerun tests 1–4 with WIDTH=8, SYNC_STAGES=3 → latency becomes k+3 and rdata[31:8]=0.

Source files
------------

// File: rtl/gpio_edge_ctrl.sv
// gpio_edge_ctrl: register-mapped GPIO with synchronised inputs, edge-detect sticky status and irq
module gpio_edge_ctrl #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    input  logic [WIDTH-1:0]  gpio_input,
    output logic [WIDTH-1:0]  gpio_output,
    output logic [WIDTH-1:0]  gpio_direction,
    output logic              irq
);
    localparam int CW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] WARM = CW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]  r_prev;
    logic [WIDTH-1:0]  r_dir;
    logic [WIDTH-1:0]  r_out;
    logic [WIDTH-1:0]  r_rise_en;
    logic [WIDTH-1:0]  r_fall_en;
    logic [WIDTH-1:0]  r_status;
    logic [CW-1:0]     r_warm;
    logic              r_irq;

    logic              w_wr;
    logic              w_rd;
    logic [ADDR_W-3:0] w_word;
    logic              w_sel_dir;
    logic              w_sel_out;
    logic              w_sel_in;
    logic              w_sel_rise;
    logic              w_sel_fall;
    logic              w_sel_sts;
    logic              w_sel_set;
    logic              w_sel_clr;
    logic [WIDTH-1:0]  w_wd;
    logic [WIDTH-1:0]  w_in;
    logic              w_armed;
    logic [WIDTH-1:0]  w_set;
    logic [WIDTH-1:0]  w_w1c;
    logic [WIDTH-1:0]  w_out_nxt;
    logic [WIDTH-1:0]  w_rmux;
    logic              w_unused;

    assign w_wr       = req & we;
    assign w_rd       = req & ~we;
    assign w_word     = addr[ADDR_W-1:2];
    assign w_sel_dir  = w_word == (ADDR_W-2)'(0);
    assign w_sel_out  = w_word == (ADDR_W-2)'(1);
    assign w_sel_in   = w_word == (ADDR_W-2)'(2);
    assign w_sel_rise = w_word == (ADDR_W-2)'(3);
    assign w_sel_fall = w_word == (ADDR_W-2)'(4);
    assign w_sel_sts  = w_word == (ADDR_W-2)'(5);
    assign w_sel_set  = w_word == (ADDR_W-2)'(6);
    assign w_sel_clr  = w_word == (ADDR_W-2)'(7);
    assign w_wd       = wdata[WIDTH-1:0];
    assign w_in       = r_sync[SYNC_STAGES-1];
    assign w_unused   = ^{addr[1:0], wdata};

    // Edge events are suppressed until the sync chain and prev sample hold real pin values
    assign w_armed = r_warm == WARM;
    assign w_set   = w_armed ? ((w_in & ~r_prev & r_rise_en) | (~w_in & r_prev & r_fall_en)) : '0;
    assign w_w1c   = (w_wr & w_sel_sts) ? w_wd : '0;

    // Next OUT value: plain write, atomic set or atomic clear
    always_comb begin
        w_out_nxt = !w_wr     ? r_out :
                    w_sel_out ? w_wd :
                    w_sel_set ? (r_out | w_wd) :
                    w_sel_clr ? (r_out & ~w_wd) : r_out;
    end

    // Read mux; write-only and unmapped offsets read as zero
    always_comb begin
        w_rmux = w_sel_dir  ? r_dir :
                 w_sel_out  ? r_out :
                 w_sel_in   ? w_in :
                 w_sel_rise ? r_rise_en :
                 w_sel_fall ? r_fall_en :
                 w_sel_sts  ? r_status : '0;
    end

    // Input synchroniser, previous sample and warm-up counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= '0;
            r_warm <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_input};
            r_prev <= w_in;
            r_warm <= w_armed ? r_warm : r_warm + CW'(1);
        end
    end

    // Control registers written from the bus
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dir     <= '0;
            r_out     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else begin
            r_out <= w_out_nxt;
            if (w_wr && w_sel_dir) r_dir <= w_wd;
            if (w_wr && w_sel_rise) r_rise_en <= w_wd;
            if (w_wr && w_sel_fall) r_fall_en <= w_wd;
        end
    end

    // Sticky status with W1C; a coinciding set beats the clear; irq follows one cycle later
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_status <= (r_status & ~w_w1c) | w_set;
            r_irq    <= |r_status;
        end
    end

    // Registered read response; rdata holds when no read is issued
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= w_rd;
            if (w_rd) rdata <= 32'(w_rmux);
        end
    end

    assign gpio_output    = r_out;
    assign gpio_direction = r_dir;
    assign irq            = r_irq;
endmodule

// File: tb/tb_gpio_edge_ctrl.sv
// tb_gpio_edge_ctrl: directed checks on a default instance and a WIDTH=8/SYNC_STAGES=3 instance sharing one bus
module tb_gpio_edge_ctrl;
    localparam logic [4:0] A_DIR = 5'h00, A_OUT = 5'h04, A_IN = 5'h08, A_RISE = 5'h0C;
    localparam logic [4:0] A_FALL = 5'h10, A_STS = 5'h14, A_SET = 5'h18, A_CLR = 5'h1C;

    logic        clock = 1'b0;
    logic        reset_n, req, we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] gi;
    logic [7:0]  gi_b;
    logic [31:0] rd_a, rd_b;
    logic        rv_a, rv_b, irq_a, irq_b;
    logic [31:0] go_a, gd_a;
    logic [7:0]  go_b, gd_b;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] ra, rb;
    logic [4:0]  va, vb;

    assign gi_b = gi[7:0];

    gpio_edge_ctrl u_a (
        .clock(clock), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rd_a), .rvalid(rv_a), .gpio_input(gi), .gpio_output(go_a),
        .gpio_direction(gd_a), .irq(irq_a)
    );

    gpio_edge_ctrl #(.WIDTH(8), .SYNC_STAGES(3), .ADDR_W(5)) u_b (
        .clock(clock), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rd_b), .rvalid(rv_b), .gpio_input(gi_b), .gpio_output(go_b),
        .gpio_direction(gd_b), .irq(irq_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] oa, output logic [31:0] ob);
        req = 1'b1; we = 1'b0; addr = a;
        tick();
        req = 1'b0;
        check("rvalid_a", 32'(rv_a), 32'd1);
        check("rvalid_b", 32'(rv_b), 32'd1);
        oa = rd_a;
        ob = rd_b;
    endtask

    task automatic rdchk(input string tag, input logic [4:0] a, input logic [31:0] ea, input logic [31:0] eb);
        logic [31:0] xa, xb;
        rd(a, xa, xb);
        check({tag, "_a"}, xa, ea);
        check({tag, "_b"}, xb, eb);
    endtask

    initial begin
        reset_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; gi = '0;
        repeat (10) @(posedge clock);
        #1 reset_n = 1'b1;
        check("rst_dir_a", gd_a, 32'h0);
        check("rst_out_a", go_a, 32'h0);
        check("rst_out_b", 32'(go_b), 32'h0);
        check("rst_irq_a", 32'(irq_a), 32'h0);
        check("rst_rvalid", 32'(rv_a), 32'h0);
        for (int i = 0; i < 8; i++) rdchk($sformatf("rst_rd%0d", i), 5'(i * 4), 32'h0, 32'h0);
        tick();
        check("rvalid_drop_a", 32'(rv_a), 32'h0);
        check("rvalid_drop_b", 32'(rv_b), 32'h0);

        wr(A_DIR, 32'hFFFF_FFFF);
        check("dir_a", gd_a, 32'hFFFF_FFFF);
        check("dir_b", 32'(gd_b), 32'h0000_00FF);
        wr(A_OUT, 32'h0000_00F0);
        check("out_a", go_a, 32'hF0);
        check("out_b", 32'(go_b), 32'hF0);
        wr(A_SET, 32'h1);
        check("set_a", go_a, 32'hF1);
        check("set_b", 32'(go_b), 32'hF1);
        wr(A_CLR, 32'hF0);
        check("clr_a", go_a, 32'h01);
        check("clr_b", 32'(go_b), 32'h01);
        rdchk("rd_out", A_OUT, 32'h01, 32'h01);
        rdchk("rd_dir", A_DIR, 32'hFFFF_FFFF, 32'h0000_00FF);
        rdchk("rd_wo_set", A_SET, 32'h0, 32'h0);
        wr(A_IN, 32'hFFFF_FFFF);
        gi = 32'hA500_005A;
        idle(5);
        rdchk("rd_in", A_IN, 32'hA500_005A, 32'h0000_005A);
        gi = '0;
        idle(6);

        wr(A_RISE, 32'h1);
        gi = 32'h1;
        for (int i = 0; i < 5; i++) begin
            tick();
            va[i] = irq_a;
            vb[i] = irq_b;
        end
        check("rise_lat_a", 32'(va), 32'(5'b11000));
        check("rise_lat_b", 32'(vb), 32'(5'b10000));
        rdchk("rise_sts", A_STS, 32'h1, 32'h1);
        wr(A_STS, 32'h1);
        check("w1c_irq_hold", 32'(irq_a), 32'h1);
        tick();
        check("w1c_irq_a", 32'(irq_a), 32'h0);
        check("w1c_irq_b", 32'(irq_b), 32'h0);
        rdchk("w1c_sts", A_STS, 32'h0, 32'h0);

        wr(A_RISE, 32'h0);
        wr(A_FALL, 32'h2);
        gi = 32'h3;
        idle(6);
        rdchk("fall_rise_ign", A_STS, 32'h0, 32'h0);
        gi = 32'h1;
        idle(6);
        rdchk("fall_sts", A_STS, 32'h2, 32'h2);
        check("fall_irq_a", 32'(irq_a), 32'h1);
        gi = 32'h0;
        idle(6);
        gi = 32'h1;
        idle(6);
        rdchk("pin0_masked", A_STS, 32'h2, 32'h2);
        wr(A_FALL, 32'h0);
        rdchk("en_no_mask", A_STS, 32'h2, 32'h2);
        check("en_no_mask_irq", 32'(irq_b), 32'h1);
        wr(A_STS, 32'h2);
        idle(2);
        rdchk("fall_clr", A_STS, 32'h0, 32'h0);

        wr(A_RISE, 32'h1);
        gi = 32'h0;
        idle(6);
        gi = 32'h1;
        idle(6);
        rdchk("pre_coll", A_STS, 32'h1, 32'h1);
        gi = 32'h0;
        idle(6);
        gi = 32'h1;
        idle(2);
        wr(A_STS, 32'h1);
        rd(A_STS, ra, rb);
        check("coll_a", ra, 32'h1);
        gi = 32'h0;
        idle(6);
        gi = 32'h1;
        idle(3);
        wr(A_STS, 32'h1);
        rdchk("coll_b", A_STS, 32'h0, 32'h1);

        req = 1'b1; we = 1'b0; addr = A_OUT;
        tick();
        req = 1'b0;
        check("pre_arst_rv", 32'(rv_a), 32'h1);
        gi = 32'hFF;
        #2 reset_n = 1'b0;
        #1;
        check("arst_rv_a", 32'(rv_a), 32'h0);
        check("arst_rv_b", 32'(rv_b), 32'h0);
        check("arst_out_a", go_a, 32'h0);
        check("arst_dir_b", 32'(gd_b), 32'h0);
        check("arst_irq_b", 32'(irq_b), 32'h0);
        idle(3);
        reset_n = 1'b1;
        wr(A_RISE, 32'hFF);
        idle(8);
        rdchk("warm_sts", A_STS, 32'h0, 32'h0);
        check("warm_irq_a", 32'(irq_a), 32'h0);
        check("warm_irq_b", 32'(irq_b), 32'h0);
        gi = 32'hFE;
        idle(6);
        gi = 32'hFF;
        idle(6);
        rdchk("post_warm", A_STS, 32'h1, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
